// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer.
package note_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_PAUSE,
    ST_END
  } state_t;

  localparam int         ADDR_W   = 8;
  localparam logic [3:0] INX_REST = 4'd0;

endpackage

// File: rtl/note_rom.sv
// Song table: combinational address-to-note lookup; addresses past SONG_LEN read as rest.
module note_rom
  import note_seq_pkg::*;
#(
  parameter int SONG_LEN = 128
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [3:0]        o_inx
);

  always_comb begin
    o_inx = INX_REST;
    if ({24'd0, i_addr} < 32'(SONG_LEN)) begin
      case (i_addr)
        8'd0:    o_inx = 4'd3;
        8'd1:    o_inx = 4'd8;
        8'd2:    o_inx = 4'd0;
        8'd3:    o_inx = 4'd15;
        8'd4:    o_inx = 4'd5;
        8'd5:    o_inx = 4'd5;
        8'd6:    o_inx = 4'd6;
        8'd7:    o_inx = 4'd8;
        8'd8:    o_inx = 4'd8;
        8'd9:    o_inx = 4'd6;
        8'd10:   o_inx = 4'd5;
        8'd11:   o_inx = 4'd3;
        8'd12:   o_inx = 4'd1;
        8'd13:   o_inx = 4'd1;
        8'd14:   o_inx = 4'd3;
        8'd15:   o_inx = 4'd5;
        default: o_inx = INX_REST;
      endcase
    end
  end

endmodule

// File: rtl/note_seq.sv
// Beat-timed song sequencer: advances one ROM entry every TICK_DIV clocks.
// Define NOTE_SEQ_LOOP_EN to wrap back to entry 0 after the last note instead of stopping.
module note_seq
  import note_seq_pkg::*;
#(
  parameter int TICK_DIV = 3000000,
  parameter int SONG_LEN = 128
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_hold,
  output logic [3:0]        o_inx,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_beat,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [23:0]       TC        = 24'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  state_t            r_state, w_stateNext;
  logic [23:0]       r_cnt, w_cntNext;
  logic [ADDR_W-1:0] r_addr, w_addrNext;
  logic [3:0]        r_inx, w_inxNext;
  logic              r_beat, w_beatNext;
  logic              r_done, w_doneNext;
  logic              w_active;
  logic [ADDR_W-1:0] w_romAddr;
  logic [3:0]        w_romInx;

  assign w_active  = (r_state == ST_PLAY) || (r_state == ST_PAUSE);
  // ROM is addressed with the entry that will be loaded on this edge.
  assign w_romAddr = (i_start || (r_addr == LAST_ADDR)) ? '0 : r_addr + ADDR_W'(1);

  note_rom #(.SONG_LEN(SONG_LEN)) u_rom (
    .i_addr(w_romAddr),
    .o_inx (w_romInx)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_inx   <= INX_REST;
      r_beat  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_addr  <= w_addrNext;
      r_inx   <= w_inxNext;
      r_beat  <= w_beatNext;
      r_done  <= w_doneNext;
    end
  end

  // HOLD gates counting directly, so a PAUSE released by HOLD=0 counts in that same cycle.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_addrNext  = r_addr;
    w_inxNext   = r_inx;
    w_beatNext  = 1'b0;
    w_doneNext  = 1'b0;
    if (i_stop) begin
      w_stateNext = ST_IDLE;
      w_cntNext   = '0;
      w_addrNext  = '0;
      w_inxNext   = INX_REST;
    end else if (i_start) begin
      w_stateNext = (w_active && i_hold) ? ST_PAUSE : ST_PLAY;
      w_cntNext   = '0;
      w_addrNext  = '0;
      w_inxNext   = w_romInx;
      w_beatNext  = 1'b1;
    end else begin
      unique case (r_state)
        ST_PLAY, ST_PAUSE: begin
          w_stateNext = i_hold ? ST_PAUSE : ST_PLAY;
          if (!i_hold) begin
            if (r_cnt != TC) begin
              w_cntNext = r_cnt + 24'd1;
            end else begin
              w_cntNext = '0;
              if (r_addr == LAST_ADDR) begin
                w_doneNext  = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
                w_addrNext  = '0;
                w_inxNext   = w_romInx;
                w_beatNext  = 1'b1;
`else
                w_stateNext = ST_END;
                w_inxNext   = INX_REST;
`endif
              end else begin
                w_addrNext = r_addr + ADDR_W'(1);
                w_inxNext  = w_romInx;
                w_beatNext = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_inx  = r_inx;
  assign o_addr = r_addr;
  assign o_beat = r_beat;
  assign o_done = r_done;
  assign o_busy = w_active;

endmodule
